// File: rtl/ntt_pair_commutator.sv
// ---------------------------------------------------------------------------
// ntt_pair_commutator
//
// Radix-2 pairing stage placed in front of the 64-bit Goldilocks add/sub
// butterfly. Elements arrive serially, one per accepted cycle. The first
// STRIDE elements of every 2*STRIDE-element block are parked in a small
// buffer. Each element of the second half is then presented together with
// its partner from the first half as an (x, y) pair. Pairs come out in k
// order 0..STRIDE-1. Element values pass through bit-exact; no reduction is
// applied.
//
// Ports:
//   clk_i          clock, rising edge
//   rst_i          synchronous reset, active-high, overrides ce_i
//   ce_i           global clock enable; low freezes all state and outputs
//   in_valid_i     in_data_i carries an element (sampled when ce_i=1)
//   in_data_i      64-bit element, any value
//   x_o            lower pair element (index k)
//   y_o            upper pair element (index k+STRIDE)
//   nop_o          1 when x_o/y_o are not a valid pair (feeds butterfly nop_i)
//   pair_idx_o     k of the current pair, for twiddle addressing
//   block_start_o  1 together with the k=0 pair of each block
//   busy_o         1 while a block is partially received
// ---------------------------------------------------------------------------
module ntt_pair_commutator #(
  parameter int STRIDE     = 8,
  parameter int LOG_STRIDE = $clog2(STRIDE)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  ce_i,
  input  logic                  in_valid_i,
  input  logic [63:0]           in_data_i,
  output logic [63:0]           x_o,
  output logic [63:0]           y_o,
  output logic                  nop_o,
  output logic [LOG_STRIDE-1:0] pair_idx_o,
  output logic                  block_start_o,
  output logic                  busy_o
);

  localparam logic [LOG_STRIDE:0]   CNT_ZERO  = {(LOG_STRIDE+1){1'b0}};
  localparam logic [LOG_STRIDE:0]   CNT_ONE   = {{LOG_STRIDE{1'b0}}, 1'b1};
  localparam logic [LOG_STRIDE-1:0] ADDR_ZERO = {LOG_STRIDE{1'b0}};

  // Accepted-element counter. Its width is exactly log2(2*STRIDE), so the
  // natural binary wrap gives the modulo-2*STRIDE behaviour with no idle slot.
  logic [LOG_STRIDE:0]   cnt_q, cnt_d;
  logic                  phase_s;
  logic [LOG_STRIDE-1:0] addr_s;
  logic                  accept_s;
  logic                  mem_we_s;

  // First-half buffer: no reset, every location is written in phase 0
  // before phase 1 reads it.
  logic [63:0] mem_q [STRIDE];

  logic [63:0]           x_q, x_d;
  logic [63:0]           y_q, y_d;
  logic                  nop_q, nop_d;
  logic [LOG_STRIDE-1:0] pair_idx_q, pair_idx_d;
  logic                  block_start_q, block_start_d;

  assign phase_s  = cnt_q[LOG_STRIDE];
  assign addr_s   = cnt_q[LOG_STRIDE-1:0];
  assign accept_s = ce_i & in_valid_i;
  // Phase 0 only writes and phase 1 only reads, so the single port never
  // sees a read/write collision.
  assign mem_we_s = accept_s & ~phase_s;

  // Next-state logic for the counter and the registered pair outputs.
  always_comb begin
    cnt_d         = cnt_q;
    x_d           = x_q;
    y_d           = y_q;
    nop_d         = nop_q;
    pair_idx_d    = pair_idx_q;
    block_start_d = block_start_q;
    if (ce_i) begin
      if (in_valid_i) begin
        cnt_d = cnt_q + CNT_ONE;
        if (phase_s) begin
          x_d           = mem_q[addr_s];
          y_d           = in_data_i;
          nop_d         = 1'b0;
          pair_idx_d    = addr_s;
          block_start_d = (addr_s == ADDR_ZERO);
        end else begin
          // Filling the buffer: no pair yet; pair_idx_o keeps its last k.
          x_d           = 64'd0;
          y_d           = 64'd0;
          nop_d         = 1'b1;
          block_start_d = 1'b0;
        end
      end else begin
        // Input gap: emit a bubble but keep the block position and k.
        x_d           = 64'd0;
        y_d           = 64'd0;
        nop_d         = 1'b1;
        block_start_d = 1'b0;
      end
    end else begin
      // Stalled: everything holds (defaults already hold).
      cnt_d = cnt_q;
    end
  end

  // Counter and output registers with synchronous reset that wins over ce_i.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q         <= CNT_ZERO;
      x_q           <= 64'd0;
      y_q           <= 64'd0;
      nop_q         <= 1'b1;
      pair_idx_q    <= ADDR_ZERO;
      block_start_q <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      x_q           <= x_d;
      y_q           <= y_d;
      nop_q         <= nop_d;
      pair_idx_q    <= pair_idx_d;
      block_start_q <= block_start_d;
    end
  end

  // First-half buffer write port (asynchronous read above).
  always_ff @(posedge clk_i) begin
    if (mem_we_s) begin
      mem_q[addr_s] <= in_data_i;
    end
  end

  assign x_o           = x_q;
  assign y_o           = y_q;
  assign nop_o         = nop_q;
  assign pair_idx_o    = pair_idx_q;
  assign block_start_o = block_start_q;
  assign busy_o        = (cnt_q != CNT_ZERO);

endmodule

// File: tb/tb_ntt_pair_commutator.sv
// ---------------------------------------------------------------------------
// Self-checking bench for ntt_pair_commutator with STRIDE=4.
// The driver pushes the expected output of every enabled edge into a
// scoreboard; a monitor on the falling edge pops and compares, and checks
// that outputs stay frozen across ce_i=0 edges. Every valid pair seen is
// also logged and compared against hand-written pair lists per scenario.
// ---------------------------------------------------------------------------
module tb_ntt_pair_commutator;

  localparam int S = 4;
  localparam int L = 2;

  logic          clk_i;
  logic          rst_i;
  logic          ce_i;
  logic          in_valid_i;
  logic [63:0]   in_data_i;
  logic [63:0]   x_o;
  logic [63:0]   y_o;
  logic          nop_o;
  logic [L-1:0]  pair_idx_o;
  logic          block_start_o;
  logic          busy_o;

  typedef struct packed {
    logic         nop;
    logic [63:0]  x;
    logic [63:0]  y;
    logic [L-1:0] idx;
    logic         bs;
    logic         busy;
  } rec_t;

  typedef struct packed {
    logic [63:0]  x;
    logic [63:0]  y;
    logic [L-1:0] idx;
    logic         bs;
  } pair_t;

  rec_t  sb_q[$];
  pair_t log_q[$];

  int checks = 0;
  int errors = 0;

  // Driver-side expectation state
  int           n;
  logic [63:0]  blk [S];
  logic [L-1:0] m_idx;

  ntt_pair_commutator #(.STRIDE(S)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .ce_i          (ce_i),
    .in_valid_i    (in_valid_i),
    .in_data_i     (in_data_i),
    .x_o           (x_o),
    .y_o           (y_o),
    .nop_o         (nop_o),
    .pair_idx_o    (pair_idx_o),
    .block_start_o (block_start_o),
    .busy_o        (busy_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // ---------------- monitor ----------------
  int   kind = 0;   // 0 none yet, 1 stalled edge, 2 enabled/reset edge
  rec_t mon_e;
  rec_t snap;

  always @(posedge clk_i) begin
    kind = (rst_i || ce_i) ? 2 : 1;
  end

  always @(negedge clk_i) begin
    if (kind == 2) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got nop=%0d x=%h expected no output", nop_o, x_o);
      end else begin
        mon_e = sb_q.pop_front();
        chk("nop",      64'(nop_o),         64'(mon_e.nop));
        chk("x",        x_o,                mon_e.x);
        chk("y",        y_o,                mon_e.y);
        chk("pair_idx", 64'(pair_idx_o),    64'(mon_e.idx));
        chk("bstart",   64'(block_start_o), 64'(mon_e.bs));
        chk("busy",     64'(busy_o),        64'(mon_e.busy));
      end
      if (nop_o == 1'b0) log_q.push_back({x_o, y_o, pair_idx_o, block_start_o});
    end else if (kind == 1) begin
      chk("frz_nop",  64'(nop_o),         64'(snap.nop));
      chk("frz_x",    x_o,                snap.x);
      chk("frz_y",    y_o,                snap.y);
      chk("frz_idx",  64'(pair_idx_o),    64'(snap.idx));
      chk("frz_bs",   64'(block_start_o), 64'(snap.bs));
      chk("frz_busy", 64'(busy_o),        64'(snap.busy));
    end
    snap = {nop_o, x_o, y_o, pair_idx_o, block_start_o, busy_o};
  end

  // ---------------- driver ----------------
  task automatic step(input logic ce, input logic v, input logic [63:0] d);
    rec_t e;
    rst_i      = 1'b0;
    ce_i       = ce;
    in_valid_i = v;
    in_data_i  = d;
    if (ce) begin
      e = '0;
      e.idx = m_idx;
      if (v) begin
        if (n < S) begin
          blk[n] = d;
          e.nop  = 1'b1;
        end else begin
          m_idx  = L'(n - S);
          e.nop  = 1'b0;
          e.x    = blk[n - S];
          e.y    = d;
          e.idx  = m_idx;
          e.bs   = (n == S);
        end
        n = (n + 1) % (2 * S);
      end else begin
        e.nop = 1'b1;
      end
      e.busy = (n != 0);
      sb_q.push_back(e);
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset(input logic ce, input logic v);
    rst_i      = 1'b1;
    ce_i       = ce;
    in_valid_i = v;
    in_data_i  = 64'h0000_0000_0000_DEAD;
    sb_q.push_back({1'b1, 64'd0, 64'd0, {L{1'b0}}, 1'b0, 1'b0});
    n     = 0;
    m_idx = '0;
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
  endtask

  task automatic flush();
    step(1'b1, 1'b0, 64'd0);
    @(negedge clk_i);
    #1;
  endtask

  task automatic expect_pair(input logic [63:0] x, input logic [63:0] y,
                             input int idx, input logic bs);
    pair_t p;
    if (log_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL missing_pair: got none expected x=%h y=%h", x, y);
    end else begin
      p = log_q.pop_front();
      chk("pair_x",   p.x,      x);
      chk("pair_y",   p.y,      y);
      chk("pair_idx", 64'(p.idx), 64'(idx));
      chk("pair_bs",  64'(p.bs),  64'(bs));
    end
  endtask

  task automatic log_done(input string nm);
    chk(nm, 64'(log_q.size()), 64'd0);
    log_q.delete();
  endtask

  initial begin
    n     = 0;
    m_idx = '0;
    do_reset(1'b0, 1'b0);

    // 1: basic block 0..7
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 64'(i));
    chk("busy_after_7", 64'(busy_o), 64'd0);
    flush();
    expect_pair(64'd0, 64'd4, 0, 1'b1);
    expect_pair(64'd1, 64'd5, 1, 1'b0);
    expect_pair(64'd2, 64'd6, 2, 1'b0);
    expect_pair(64'd3, 64'd7, 3, 1'b0);
    log_done("s1_extra_pairs");

    // 2: back-to-back blocks
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 64'(16'h10 + i));
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 64'(16'h20 + i));
    flush();
    expect_pair(64'h10, 64'h14, 0, 1'b1);
    expect_pair(64'h11, 64'h15, 1, 1'b0);
    expect_pair(64'h12, 64'h16, 2, 1'b0);
    expect_pair(64'h13, 64'h17, 3, 1'b0);
    expect_pair(64'h20, 64'h24, 0, 1'b1);
    expect_pair(64'h21, 64'h25, 1, 1'b0);
    expect_pair(64'h22, 64'h26, 2, 1'b0);
    expect_pair(64'h23, 64'h27, 3, 1'b0);
    log_done("s2_extra_pairs");

    // 3: gaps after elements 1, 4 and 6
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b1, 64'(i));
      if (i == 1 || i == 4 || i == 6) step(1'b1, 1'b0, 64'hFFFF);
    end
    flush();
    expect_pair(64'd0, 64'd4, 0, 1'b1);
    expect_pair(64'd1, 64'd5, 1, 1'b0);
    expect_pair(64'd2, 64'd6, 2, 1'b0);
    expect_pair(64'd3, 64'd7, 3, 1'b0);
    log_done("s3_extra_pairs");

    // 4: ce_i low for 3 cycles in phase 1, with in_valid_i pulses ignored
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b1, 64'(16'h40 + i));
      if (i == 5) begin
        step(1'b0, 1'b1, 64'hBAD0);
        step(1'b0, 1'b0, 64'hBAD1);
        step(1'b0, 1'b1, 64'hBAD2);
      end
    end
    flush();
    expect_pair(64'h40, 64'h44, 0, 1'b1);
    expect_pair(64'h41, 64'h45, 1, 1'b0);
    expect_pair(64'h42, 64'h46, 2, 1'b0);
    expect_pair(64'h43, 64'h47, 3, 1'b0);
    log_done("s4_extra_pairs");

    // 5: reset after 5 accepted elements, then a fresh block
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 64'(16'h50 + i));
    do_reset(1'b1, 1'b1);
    chk("rst_nop",  64'(nop_o),  64'd1);
    chk("rst_busy", 64'(busy_o), 64'd0);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 64'(16'hA0 + i));
    flush();
    expect_pair(64'h50, 64'h54, 0, 1'b1);
    expect_pair(64'hA0, 64'hA4, 0, 1'b1);
    expect_pair(64'hA1, 64'hA5, 1, 1'b0);
    expect_pair(64'hA2, 64'hA6, 2, 1'b0);
    expect_pair(64'hA3, 64'hA7, 3, 1'b0);
    log_done("s5_extra_pairs");

    // 6: extreme values pass through untouched
    step(1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
    step(1'b1, 1'b1, 64'd1);
    step(1'b1, 1'b1, 64'd2);
    step(1'b1, 1'b1, 64'd3);
    step(1'b1, 1'b1, 64'hFFFF_FFFF_0000_0001);
    step(1'b1, 1'b1, 64'd5);
    step(1'b1, 1'b1, 64'd6);
    step(1'b1, 1'b1, 64'd7);
    flush();
    expect_pair(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_0000_0001, 0, 1'b1);
    expect_pair(64'd1, 64'd5, 1, 1'b0);
    expect_pair(64'd2, 64'd6, 2, 1'b0);
    expect_pair(64'd3, 64'd7, 3, 1'b0);
    log_done("s6_extra_pairs");

    chk("scoreboard_drained", 64'(sb_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
